// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters.
// Define ALU_OP_CHECK_EN to add rsp_err and reject opcodes outside ADD..SRL.
`ifndef ADD
`define ADD 6'b100000
`endif
`ifndef SUB
`define SUB 6'b100010
`endif
`ifndef AND
`define AND 6'b100100
`endif
`ifndef OR
`define OR  6'b100101
`endif
`ifndef XOR
`define XOR 6'b100110
`endif
`ifndef NOR
`define NOR 6'b100111
`endif
`ifndef SRA
`define SRA 6'b000011
`endif
`ifndef SRL
`define SRL 6'b000010
`endif

module alu_arbiter #(
   parameter int N_BITS = 8,
   parameter int N_OP   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [N_BITS-1:0] req0_a,
   input  logic [N_BITS-1:0] req0_b,
   input  logic [N_OP-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [N_BITS-1:0] req1_a,
   input  logic [N_BITS-1:0] req1_b,
   input  logic [N_OP-1:0]   req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [N_BITS-1:0] rsp_rdo,
   output logic              rsp_carry,
   output logic              rsp_zero,
`ifdef ALU_OP_CHECK_EN
   output logic              rsp_err,
`endif
   output logic [N_BITS-1:0] alu_a,
   output logic [N_BITS-1:0] alu_b,
   output logic [N_OP-1:0]   alu_op,
   input  logic [N_BITS-1:0] alu_rdo,
   input  logic              alu_carry,
   input  logic              alu_zero
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [N_BITS-1:0]   a_q, a_d, b_q, b_d;
   logic [N_OP-1:0]     op_q, op_d;
   logic                id_q, id_d;
   logic                last_grant_q, last_grant_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_id_q, rsp_id_d;
   logic [N_BITS-1:0]   rsp_rdo_q, rsp_rdo_d;
   logic                rsp_carry_q, rsp_carry_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                rsp_err_q, rsp_err_d;

   logic                any_valid;
   logic                sel_id;
   logic [N_BITS-1:0]   sel_a, sel_b;
   logic [N_OP-1:0]     sel_op;
   logic                op_ok;

   assign any_valid = req0_valid | req1_valid;
   // On a tie the requester that did not win last time gets the grant.
   assign sel_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
   assign sel_a  = sel_id ? req1_a  : req0_a;
   assign sel_b  = sel_id ? req1_b  : req0_b;
   assign sel_op = sel_id ? req1_op : req0_op;

`ifdef ALU_OP_CHECK_EN
   localparam logic [N_OP-1:0] OP_ADD = N_OP'(`ADD);
   localparam logic [N_OP-1:0] OP_SUB = N_OP'(`SUB);
   localparam logic [N_OP-1:0] OP_AND = N_OP'(`AND);
   localparam logic [N_OP-1:0] OP_OR  = N_OP'(`OR);
   localparam logic [N_OP-1:0] OP_XOR = N_OP'(`XOR);
   localparam logic [N_OP-1:0] OP_NOR = N_OP'(`NOR);
   localparam logic [N_OP-1:0] OP_SRA = N_OP'(`SRA);
   localparam logic [N_OP-1:0] OP_SRL = N_OP'(`SRL);

   assign op_ok = sel_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                 OP_XOR, OP_NOR, OP_SRA, OP_SRL};
   assign rsp_err = rsp_err_q;
`else
   assign op_ok = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_rdo_d    = rsp_rdo_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (any_valid && !reset) begin
               req0_ready = ~sel_id;
               req1_ready = sel_id;
               id_d       = sel_id;
               if (op_ok) begin
                  a_d     = sel_a;
                  b_d     = sel_b;
                  op_d    = sel_op;
                  state_d = S_EXEC;
               end else begin
                  // Rejected opcode: the alu keeps its previous operands.
                  rsp_valid_d  = 1'b1;
                  rsp_id_d     = sel_id;
                  rsp_rdo_d    = '0;
                  rsp_carry_d  = 1'b0;
                  rsp_zero_d   = 1'b0;
                  rsp_err_d    = 1'b1;
                  last_grant_d = sel_id;
                  state_d      = S_RESP;
               end
            end
         end
         S_EXEC: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_rdo_d    = alu_rdo;
            rsp_carry_d  = alu_carry;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = 1'b0;
            last_grant_d = id_q;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_rdo_q    <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_rdo_q    <= rsp_rdo_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdo   = rsp_rdo_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural alu on the alu_* ports.
// Build with ALU_OP_CHECK_EN defined to also exercise opcode rejection.
`timescale 1ns/1ps
`ifndef ADD
`define ADD 6'b100000
`endif
`ifndef SUB
`define SUB 6'b100010
`endif
`ifndef AND
`define AND 6'b100100
`endif
`ifndef OR
`define OR  6'b100101
`endif
`ifndef XOR
`define XOR 6'b100110
`endif
`ifndef NOR
`define NOR 6'b100111
`endif
`ifndef SRA
`define SRA 6'b000011
`endif
`ifndef SRL
`define SRL 6'b000010
`endif

module tb_alu_arbiter;

   typedef struct packed {
      logic       id;
      logic [7:0] rdo;
      logic       carry;
      logic       zero;
      logic       err;
   } rsp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [5:0] req0_op, req1_op;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
   logic [7:0] rsp_rdo;
   logic       rsp_err_w;
   logic [7:0] alu_a, alu_b, alu_rdo;
   logic [5:0] alu_op;
   logic       alu_carry, alu_zero;

   int   vectors = 0;
   int   miscompares = 0;
   rsp_t exp_q[$];
   rsp_t obs_q[$];

   always #5 clk = ~clk;

   alu_arbiter #(.N_BITS(8), .N_OP(6)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_rdo(rsp_rdo), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
`ifdef ALU_OP_CHECK_EN
      .rsp_err(rsp_err_w),
`endif
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_rdo(alu_rdo), .alu_carry(alu_carry), .alu_zero(alu_zero)
   );

`ifndef ALU_OP_CHECK_EN
   assign rsp_err_w = 1'b0;
`endif

   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
      logic [7:0] sra;
      sra = $signed(a) >>> b;
      case (op)
         `ADD:    alu_fn = {1'b0, a} + {1'b0, b};
         `SUB:    alu_fn = {1'b0, a} - {1'b0, b};
         `AND:    alu_fn = {1'b0, a & b};
         `OR:     alu_fn = {1'b0, a | b};
         `XOR:    alu_fn = {1'b0, a ^ b};
         `NOR:    alu_fn = {1'b0, ~(a | b)};
         `SRA:    alu_fn = {1'b0, sra};
         `SRL:    alu_fn = {1'b0, a >> b};
         default: alu_fn = 9'h000;
      endcase
   endfunction

   assign {alu_carry, alu_rdo} = alu_fn(alu_a, alu_b, alu_op);
   assign alu_zero = (alu_rdo == 8'h00);

   // Record each response handshake; sampled mid-cycle so values are settled.
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready)
         obs_q.push_back('{id: rsp_id, rdo: rsp_rdo, carry: rsp_carry,
                           zero: rsp_zero, err: rsp_err_w});
   end

   function automatic string fmt(input rsp_t r);
      return $sformatf("id=%0d rdo=%02h c=%0d z=%0d e=%0d", r.id, r.rdo, r.carry, r.zero, r.err);
   endfunction

   task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] op, output bit ok);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = id ? req1_ready : req0_ready;
      end
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk); #1;
         ok = (obs_q.size() >= n);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = `ADD;
      req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = `ADD;
      repeat (2) @(negedge clk);
      vectors++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctrl: valid/rdy0/rdy1=%b required 000", {rsp_valid, req0_ready, req1_ready});
      end
      vectors++;
      if ({alu_a, alu_b, alu_op, rsp_rdo, rsp_id, rsp_carry, rsp_zero, rsp_err_w} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: alu_a=%h alu_b=%h alu_op=%h rdo=%h id=%0d required all 0",
                  alu_a, alu_b, alu_op, rsp_rdo, rsp_id);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; reset = 1'b0;
      $display("reset: checked idle outputs");
   endtask

   task automatic test_add_latency();
      bit ok; rsp_t got, exp;
      exp_q.delete(); obs_q.delete();
      rsp_ready = 1'b1;
      exp_q.push_back('{id: 1'b0, rdo: 8'd14, carry: 1'b1, zero: 1'b0, err: 1'b0});
      send(1'b0, 8'd250, 8'd20, `ADD, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL add_accept: req0_ready never 1 required 1"); end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_exec_cycle: rsp_valid=%b required 0", rsp_valid); end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: rsp_valid=%b required 1", rsp_valid); end
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL add_rsp: no response required 1"); end
      else begin
         got = obs_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin miscompares++; $display("FAIL add_rsp: got %s required %s", fmt(got), fmt(exp)); end
         $display("add: 250+20 -> %s", fmt(got));
      end
   endtask

   task automatic test_sub_zero();
      bit ok; rsp_t got, exp;
      exp_q.delete(); obs_q.delete();
      exp_q.push_back('{id: 1'b1, rdo: 8'd0, carry: 1'b0, zero: 1'b1, err: 1'b0});
      send(1'b1, 8'd250, 8'd250, `SUB, ok);
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL sub_rsp: no response required 1"); end
      else begin
         got = obs_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin miscompares++; $display("FAIL sub_rsp: got %s required %s", fmt(got), fmt(exp)); end
         $display("sub: 250-250 -> %s", fmt(got));
      end
   endtask

   task automatic test_round_robin();
      rsp_t got, exp;
      do_reset();
      exp_q.delete(); obs_q.delete();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         exp_q.push_back('{id: i[0], rdo: i[0] ? 8'hFA : 8'hA0, carry: 1'b0, zero: 1'b0, err: 1'b0});
      req0_a = 8'hAA; req0_b = 8'hF0; req0_op = `AND; req0_valid = 1'b1;
      req1_a = 8'hAA; req1_b = 8'hF0; req1_op = `OR;  req1_valid = 1'b1;
      for (int i = 0; i < 100 && obs_q.size() < 4; i++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         exp = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL rr_rsp%0d: missing, required %s", i, fmt(exp));
         end else begin
            got = obs_q.pop_front();
            if (got !== exp) begin miscompares++; $display("FAIL rr_rsp%0d: got %s required %s", i, fmt(got), fmt(exp)); end
            $display("rr%0d: %s", i, fmt(got));
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok; rsp_t got, exp;
      exp_q.delete(); obs_q.delete();
      rsp_ready = 1'b0;
      exp_q.push_back('{id: 1'b0, rdo: 8'h18, carry: 1'b0, zero: 1'b0, err: 1'b0});
      send(1'b0, 8'hC0, 8'd3, `SRL, ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); ok = rsp_valid; end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL bp_valid: rsp_valid=0 required 1"); end
      // Both requesters keep asking; neither may be accepted while the response waits.
      req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = `ADD;
      req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h02; req1_op = `SUB;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({rsp_valid, rsp_rdo, req0_ready, req1_ready} !== {1'b1, 8'h18, 2'b00}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: valid=%b rdo=%h rdy=%b%b required valid=1 rdo=18 rdy=00",
                     i, rsp_valid, rsp_rdo, req0_ready, req1_ready);
         end
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL bp_rsp: no response required 1"); end
      else begin
         got = obs_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin miscompares++; $display("FAIL bp_rsp: got %s required %s", fmt(got), fmt(exp)); end
         $display("srl backpressure: %s", fmt(got));
      end
      repeat (4) @(posedge clk); #1;
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("FAIL bp_single: %0d extra responses required 0", obs_q.size()); end
      vectors++;
      if ({alu_a, alu_b, alu_op} !== {8'hC0, 8'd3, `SRL}) begin
         miscompares++;
         $display("FAIL bp_alu_hold: a=%h b=%h op=%h required a=c0 b=03 op=%h", alu_a, alu_b, alu_op, `SRL);
      end
   endtask

   task automatic test_reset_mid();
      bit ok; rsp_t got, exp;
      exp_q.delete(); obs_q.delete();
      rsp_ready = 1'b1;
      send(1'b0, 8'd1, 8'd2, `ADD, ok);
      reset = 1'b1;
      #1;
      vectors++;
      if ({rsp_valid, alu_op} !== {1'b0, 6'h00}) begin
         miscompares++; $display("FAIL rst_mid: valid=%b alu_op=%h required valid=0 op=00", rsp_valid, alu_op);
      end
      @(posedge clk); #1 reset = 1'b0;
      repeat (6) @(posedge clk); #1;
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("FAIL rst_mid_drop: %0d responses required 0", obs_q.size()); end
      exp_q.push_back('{id: 1'b1, rdo: 8'hF0, carry: 1'b0, zero: 1'b0, err: 1'b0});
      send(1'b1, 8'h0F, 8'hFF, `XOR, ok);
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rst_next_rsp: no response required 1"); end
      else begin
         got = obs_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin miscompares++; $display("FAIL rst_next_rsp: got %s required %s", fmt(got), fmt(exp)); end
         $display("after mid reset: %s", fmt(got));
      end
   endtask

`ifdef ALU_OP_CHECK_EN
   task automatic test_illegal_op();
      bit ok; rsp_t got, exp;
      exp_q.delete(); obs_q.delete();
      rsp_ready = 1'b1;
      exp_q.push_back('{id: 1'b0, rdo: 8'h00, carry: 1'b0, zero: 1'b0, err: 1'b1});
      send(1'b0, 8'h12, 8'h34, 6'h3F, ok);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL ill_skip_exec: rsp_valid=%b required 1", rsp_valid); end
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL ill_rsp: no response required 1"); end
      else begin
         got = obs_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin miscompares++; $display("FAIL ill_rsp: got %s required %s", fmt(got), fmt(exp)); end
         $display("illegal op 3f: %s", fmt(got));
      end
      vectors++;
      if ({alu_a, alu_op} !== {8'h0F, `XOR}) begin
         miscompares++; $display("FAIL ill_alu_hold: a=%h op=%h required a=0f op=%h", alu_a, alu_op, `XOR);
      end
      exp_q.push_back('{id: 1'b0, rdo: 8'h5A, carry: 1'b0, zero: 1'b0, err: 1'b0});
      send(1'b0, 8'h55, 8'h0F, `XOR, ok);
      wait_obs(1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL legal_rsp: no response required 1"); end
      else begin
         got = obs_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin miscompares++; $display("FAIL legal_rsp: got %s required %s", fmt(got), fmt(exp)); end
         $display("legal xor after illegal: %s", fmt(got));
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add_latency();
      test_sub_zero();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef ALU_OP_CHECK_EN
      test_illegal_op();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
